rom_stream_reader: RTL and testbench

- Initiator-side companion to the team's one-hot-addressed, enable-gated ROM (1-cycle registered read, output 0 while disabled).
- On a start pulse, walks all ROM entries in index order, driving rom_en and a one-hot rom_addr, and absorbs the 1-cycle read latency.
- Streams each byte out over a valid/ready interface with full backpressure and accumulates a running checksum.
- Sits between the ROM and downstream consumers (MAC/FIFO datapath).

---
 rtl/rom_stream_reader_if.sv | 22 ++
 rtl/rom_stream_reader.sv | 113 +++++++++++
 tb/tb_rom_stream_reader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_stream_reader_if.sv
// ROM read port plus valid/ready byte stream between rom_stream_reader and its neighbours.
interface rom_stream_reader_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
);
  logic              rom_en;
  logic [DEPTH-1:0]  rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (
    output rom_en, rom_addr, dout, dout_valid,
    input  rom_data, dout_ready
  );

  modport slave (
    input  rom_en, rom_addr, dout, dout_valid,
    output rom_data, dout_ready
  );
endinterface

// File: rtl/rom_stream_reader.sv
// Sweeps a one-hot-addressed ROM on start, streams each byte through a 2-entry buffer
// with full backpressure and keeps a running checksum of delivered bytes.
module rom_stream_reader #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [DATA_W+$clog2(DEPTH)-1:0] o_checksum,
  rom_stream_reader_if.master             bus
);
  localparam int CS_W  = DATA_W + $clog2(DEPTH);
  localparam int IDX_W = $clog2(DEPTH + 1);
  localparam logic [DEPTH-1:0] ADDR_ONE = DEPTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_inflight;
  logic [IDX_W-1:0]  r_idx;
  logic [1:0]        r_occ;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [DATA_W-1:0] r_mem [2];
  logic [CS_W-1:0]   r_checksum;

  logic              w_valid;
  logic              w_pop;
  logic              w_issue;
  logic              w_last_issue;
  logic [2:0]        w_load;
  logic [DATA_W-1:0] w_head;

  assign w_valid      = (r_occ != 2'd0);
  assign w_pop        = w_valid && bus.dout_ready;
  assign w_head       = r_mem[r_rd_ptr];
  // Slots committed for the coming edge: buffered + returning word - word leaving now.
  assign w_load       = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue      = (r_state == S_READ) && (r_idx < IDX_W'(DEPTH)) && (w_load < 3'd2);
  assign w_last_issue = w_issue && (r_idx == IDX_W'(DEPTH - 1));

  assign bus.rom_en     = w_issue;
  assign bus.rom_addr   = w_issue ? (ADDR_ONE << r_idx) : '0;
  assign bus.dout_valid = w_valid;
  assign bus.dout       = w_valid ? w_head : '0;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_checksum     = r_checksum;

  // NOTE: buffer storage has no reset; occupancy is reset and dout is gated by valid,
  // so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (r_inflight) r_mem[r_wr_ptr] <= bus.rom_data;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_inflight <= 1'b0;
      r_idx      <= '0;
      r_occ      <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_checksum <= '0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      r_occ      <= r_occ + 2'(r_inflight) - 2'(w_pop);
      if (w_issue)    r_idx    <= r_idx + IDX_W'(1);
      if (r_inflight) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop) begin
        r_rd_ptr   <= ~r_rd_ptr;
        r_checksum <= r_checksum + CS_W'(w_head);
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_READ;
            r_busy     <= 1'b1;
            r_idx      <= '0;
            r_checksum <= '0;
          end
        end
        S_READ: begin
          if (w_last_issue) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_load == 3'd0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader: ROM model, stream monitor and per-scenario tests.
module tb_rom_stream_reader;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;
  localparam int CS_W   = 11;
  localparam logic [CS_W-1:0] EXP_SUM = 11'h222;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            busy;
  logic            done;
  logic [CS_W-1:0] checksum;

  rom_stream_reader_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  rom_stream_reader #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .o_busy     (busy),
    .o_done     (done),
    .o_checksum (checksum),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [8] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};
  logic [7:0] rom_word;

  always_comb begin
    rom_word = '0;
    for (int i = 0; i < DEPTH; i++) if (bus.rom_addr[i]) rom_word = rom[i];
  end

  always @(posedge clk) bus.rom_data <= bus.rom_en ? rom_word : 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  int         n_beats, n_en_pre, n_done, n_viol, m_occ, m_infl, m_hs;
  bit         seen_pop;
  logic [7:0] cap [16];

  initial begin
    n_beats = 0; n_en_pre = 0; n_done = 0; n_viol = 0; m_occ = 0; m_infl = 0; seen_pop = 0;
    forever begin
      @(negedge clk);
      if (done) n_done++;
      if (rst) begin
        m_occ = 0; m_infl = 0;
      end else begin
        m_hs = (bus.dout_valid && bus.dout_ready) ? 1 : 0;
        if (bus.rom_en && (m_occ + m_infl - m_hs) >= 2) n_viol++;
        if (m_hs == 1) begin
          if (n_beats < 16) cap[n_beats] = bus.dout;
          n_beats++;
        end
        if (!seen_pop) begin
          if (m_hs == 1) seen_pop = 1;
          else if (bus.rom_en) n_en_pre++;
        end
        m_occ  = m_occ + m_infl - m_hs;
        m_infl = bus.rom_en ? 1 : 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_beats = 0; n_en_pre = 0; n_done = 0; n_viol = 0; seen_pop = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      if (done) ok = 1'b1;
      else begin
        if (toggle) bus.dout_ready = ~bus.dout_ready;
        tick();
        n++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bus.dout_ready = 1'b0;
    tick(); tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0h exp=0", done); end
    n_tests++; if ({bus.rom_en, bus.rom_addr} !== 9'h000) begin n_fail++; $display("FAIL reset_rom got=%0h exp=0", {bus.rom_en, bus.rom_addr}); end
    n_tests++; if ({bus.dout_valid, bus.dout} !== 9'h000) begin n_fail++; $display("FAIL reset_dout got=%0h exp=0", {bus.dout_valid, bus.dout}); end
    n_tests++; if (checksum !== 11'h000) begin n_fail++; $display("FAIL reset_checksum got=%0h exp=0", checksum); end
    start = 1'b1; tick();
    rst = 1'b0; start = 1'b0; tick();
    n_tests++; if ({busy, bus.rom_en} !== 2'b00) begin n_fail++; $display("FAIL start_with_rst got=%0b exp=00", {busy, bus.rom_en}); end
  endtask

  task automatic test_basic_sweep();
    logic [7:0] ea;
    int bad;
    clear_mon();
    bus.dout_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      ea = 8'h01 << i;
      n_tests++; if ({bus.rom_en, bus.rom_addr} !== {1'b1, ea}) begin n_fail++; $display("FAIL basic_addr%0d got=%0h exp=%0h", i, {bus.rom_en, bus.rom_addr}, {1'b1, ea}); end
      if (i == 1) begin
        n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%0b exp=0", bus.dout_valid); end
      end
      if (i == 2) begin
        n_tests++; if ({bus.dout_valid, bus.dout} !== 9'h124) begin n_fail++; $display("FAIL basic_first_valid got=%0h exp=124", {bus.dout_valid, bus.dout}); end
      end
      tick();
    end
    n_tests++; if (bus.rom_en !== 1'b0) begin n_fail++; $display("FAIL basic_extra_read got=%0b exp=0", bus.rom_en); end
    tick();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_early got=%0b exp=0", done); end
    tick();
    n_tests++; if ({busy, done} !== 2'b11) begin n_fail++; $display("FAIL basic_done_cycle11 got=%0b exp=11", {busy, done}); end
    tick();
    n_tests++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL basic_idle_after got=%0b exp=00", {busy, done}); end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (cap[i] !== rom[i]) bad++;
    n_tests++; if (n_beats !== 8 || bad != 0) begin n_fail++; $display("FAIL basic_stream beats=%0d bad=%0d exp beats=8 bad=0", n_beats, bad); end
    n_tests++; if (checksum !== EXP_SUM) begin n_fail++; $display("FAIL basic_checksum got=%0h exp=%0h", checksum, EXP_SUM); end
    n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL basic_done_count got=%0d exp=1", n_done); end
  endtask

  task automatic test_backpressure();
    int n, bad;
    bit ok;
    clear_mon();
    bus.dout_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!bus.dout_valid && n < 10) begin tick(); n++; end
    n_tests++; if (bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_timeout got=%0b exp=1", bus.dout_valid); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if ({bus.dout_valid, bus.dout} !== 9'h124) bad++;
      tick();
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold bad_cycles=%0d exp=0", bad); end
    bus.dout_ready = 1'b1;
    wait_done(40, 1'b0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_done_timeout got=0 exp=1"); end
    tick();
    n_tests++; if (n_en_pre > 2) begin n_fail++; $display("FAIL bp_reads_before_pop got=%0d exp<=2", n_en_pre); end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (cap[i] !== rom[i]) bad++;
    n_tests++; if (n_beats !== 8 || bad != 0) begin n_fail++; $display("FAIL bp_stream beats=%0d bad=%0d exp beats=8 bad=0", n_beats, bad); end
    n_tests++; if (checksum !== EXP_SUM) begin n_fail++; $display("FAIL bp_checksum got=%0h exp=%0h", checksum, EXP_SUM); end
    n_tests++; if (n_viol !== 0) begin n_fail++; $display("FAIL bp_issue_rule violations=%0d exp=0", n_viol); end
  endtask

  task automatic test_toggle_ready();
    int bad;
    bit ok;
    clear_mon();
    bus.dout_ready = 1'b1;
    pulse_start();
    wait_done(80, 1'b1, ok);
    bus.dout_ready = 1'b1;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL toggle_done_timeout got=0 exp=1"); end
    tick(); tick(); tick();
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (cap[i] !== rom[i]) bad++;
    n_tests++; if (n_beats !== 8 || bad != 0) begin n_fail++; $display("FAIL toggle_stream beats=%0d bad=%0d exp beats=8 bad=0", n_beats, bad); end
    n_tests++; if (n_viol !== 0) begin n_fail++; $display("FAIL toggle_issue_rule violations=%0d exp=0", n_viol); end
    n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL toggle_done_count got=%0d exp=1", n_done); end
    n_tests++; if (checksum !== EXP_SUM) begin n_fail++; $display("FAIL toggle_checksum got=%0h exp=%0h", checksum, EXP_SUM); end
  endtask

  task automatic test_reset_mid_sweep();
    int bad;
    bit ok;
    clear_mon();
    bus.dout_ready = 1'b1;
    pulse_start();
    tick(); tick();
    tick();
    n_tests++; if (checksum !== 11'h024) begin n_fail++; $display("FAIL midrst_pre_checksum got=%0h exp=24", checksum); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if ({busy, bus.dout_valid, done} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags got=%0b exp=000", {busy, bus.dout_valid, done}); end
    n_tests++; if (checksum !== 11'h000) begin n_fail++; $display("FAIL midrst_checksum got=%0h exp=0", checksum); end
    tick();
    n_tests++; if ({bus.dout_valid, bus.rom_en} !== 2'b00) begin n_fail++; $display("FAIL midrst_word_pushed got=%0b exp=00", {bus.dout_valid, bus.rom_en}); end
    tick();
    n_tests++; if (n_done !== 0) begin n_fail++; $display("FAIL midrst_done_pulse got=%0d exp=0", n_done); end
    clear_mon();
    pulse_start();
    wait_done(30, 1'b0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL midrst_resweep_timeout got=0 exp=1"); end
    tick();
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (cap[i] !== rom[i]) bad++;
    n_tests++; if (n_beats !== 8 || bad != 0 || checksum !== EXP_SUM) begin n_fail++; $display("FAIL midrst_resweep beats=%0d bad=%0d sum=%0h exp 8/0/%0h", n_beats, bad, checksum, EXP_SUM); end
  endtask

  task automatic test_start_ignored();
    int bad;
    bit ok;
    clear_mon();
    bus.dout_ready = 1'b1;
    pulse_start();
    tick(); tick();
    pulse_start();
    wait_done(30, 1'b0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL restart_done_timeout got=0 exp=1"); end
    pulse_start();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_in_done_busy got=%0b exp=0", busy); end
    tick();
    n_tests++; if ({busy, bus.rom_en} !== 2'b00) begin n_fail++; $display("FAIL restart_in_done_idle got=%0b exp=00", {busy, bus.rom_en}); end
    tick(); tick();
    n_tests++; if (n_beats !== 8 || n_done !== 1) begin n_fail++; $display("FAIL restart_single_sweep beats=%0d dones=%0d exp 8/1", n_beats, n_done); end
    pulse_start();
    n_tests++; if ({busy, checksum} !== {1'b1, 11'h000}) begin n_fail++; $display("FAIL restart_clear got busy=%0b sum=%0h exp 1/0", busy, checksum); end
    wait_done(30, 1'b0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL restart2_done_timeout got=0 exp=1"); end
    tick();
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (cap[8 + i] !== rom[i]) bad++;
    n_tests++; if (n_beats !== 16 || bad != 0 || checksum !== EXP_SUM) begin n_fail++; $display("FAIL restart2_sweep beats=%0d bad=%0d sum=%0h exp 16/0/%0h", n_beats, bad, checksum, EXP_SUM); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.dout_ready = 1'b0;
    test_reset();
    test_basic_sweep();
    test_backpressure();
    test_toggle_ready();
    test_reset_mid_sweep();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
